// File: rtl/point_fetch_ctrl.sv
// point_fetch_ctrl: builds DIM-coordinate points from a flat coordinate RAM.
// It reads DIM consecutive words per point, packs them into one word, and
// offers each point on a valid/ready port.
// Optional build macro: PFC_ABORT_EN adds an abort input that cancels a
// running request. When the macro is undefined the port does not exist.
module point_fetch_ctrl #(
    parameter int DIM     = 3,
    parameter int COORD_W = 32,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef PFC_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       num_pts,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [COORD_W-1:0]     mem_rd_data,
    output logic                   pt_valid,
    input  logic                   pt_ready,
    output logic [DIM*COORD_W-1:0] pt_data,
    output logic [CNT_W-1:0]       pt_index
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Request range check is done wide enough that base + num*DIM cannot wrap.
    localparam int CHK_W = ADDR_W + CNT_W + 4;

    logic [2:0]                        state_q, state_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d;
    logic [CNT_W-1:0]                  num_q, num_d;
    logic [CNT_W-1:0]                  idx_q, idx_d;
    logic [3:0]                        rd_cnt_q, rd_cnt_d;
    logic                              rd_vld_q, rd_vld_d;
    logic [3:0]                        rd_slot_q, rd_slot_d;
    logic [DIM-1:0][COORD_W-1:0]       asm_q, asm_d;
    logic                              done_q, done_d;
    logic                              err_q, err_d;

    logic [CHK_W-1:0]                  req_end;
    logic [CHK_W-1:0]                  req_lim;
    logic                              req_bad;
    logic                              last_pt;

    assign req_end = CHK_W'(base_addr) + CHK_W'(num_pts) * CHK_W'(DIM);
    assign req_lim = CHK_W'(1) << ADDR_W;
    assign req_bad = (num_pts == '0) || (req_end > req_lim);
    assign last_pt = (idx_q == num_q - CNT_W'(1));

    // Next-state logic: sequencing, read issue, data capture and pulses.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        num_d     = num_q;
        idx_d     = idx_q;
        rd_cnt_d  = rd_cnt_q;
        rd_vld_d  = 1'b0;
        rd_slot_d = rd_slot_q;
        asm_d     = asm_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Read data returns one cycle after the strobe; drop it into its slot.
        for (int k = 0; k < DIM; k++) begin
            if (rd_vld_q && (rd_slot_q == 4'(k))) begin
                asm_d[k] = mem_rd_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        addr_d   = base_addr;
                        num_d    = num_pts;
                        idx_d    = '0;
                        rd_cnt_d = '0;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                rd_vld_d  = 1'b1;
                rd_slot_d = rd_cnt_q;
                addr_d    = addr_q + ADDR_W'(1);
                if (rd_cnt_q == 4'(DIM - 1)) begin
                    rd_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (pt_ready) begin
                    if (last_pt) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PFC_ABORT_EN
        // Abort wins over everything else, including a same-cycle handshake.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            rd_vld_d = 1'b0;
            rd_cnt_d = '0;
            idx_d    = idx_q;
            done_d   = 1'b1;
            err_d    = 1'b1;
        end
`endif
    end

    // State registers; reset clears everything, including any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_slot_q <= '0;
            asm_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_slot_q <= rd_slot_d;
            asm_q     <= asm_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_rd_en = (state_q == S_FETCH);
    assign mem_addr  = mem_rd_en ? addr_q : '0;
    assign pt_valid  = (state_q == S_EMIT);
    assign pt_data   = asm_q;
    assign pt_index  = idx_q;
    // done_q carries reject/abort pulses, which never overlap the DONE state.
    assign done      = done_q || (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_point_fetch_ctrl.sv
// Self-checking bench for point_fetch_ctrl (DIM=3, 32-bit coordinates).
module tb_point_fetch_ctrl;

    localparam int DIM     = 3;
    localparam int COORD_W = 32;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 8;
    localparam int PW      = DIM * COORD_W;
    localparam int LIMIT   = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic              abort;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_pts;
    logic              busy, done, err, mem_rd_en, pt_valid, pt_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [COORD_W-1:0] mem_rd_data;
    logic [PW-1:0]     pt_data;
    logic [CNT_W-1:0]  pt_index;

    always #5 clk = ~clk;

    point_fetch_ctrl #(.DIM(DIM), .COORD_W(COORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
`ifdef PFC_ABORT_EN
        .abort(abort),
`endif
        .start(start), .base_addr(base_addr), .num_pts(num_pts),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_index(pt_index)
    );

    // Coordinate RAM with one-cycle read latency.
    logic [COORD_W-1:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    // Observed activity, sampled mid-cycle.
    int                done_cnt, err_cnt;
    logic [ADDR_W-1:0] rd_q[$];
    logic [PW-1:0]     hs_data[$];
    logic [CNT_W-1:0]  hs_idx[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (pt_valid && pt_ready) begin
            hs_data.push_back(pt_data);
            hs_idx.push_back(pt_index);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        done_cnt = 0;
        err_cnt  = 0;
        rd_q.delete();
        hs_data.delete();
        hs_idx.delete();
    endtask

    // Reference: point k of a request is the DIM words starting at base + k*DIM.
    function automatic logic [PW-1:0] exp_pt(input int base, input int k);
        logic [PW-1:0] p;
        for (int j = 0; j < DIM; j++) p[j*COORD_W +: COORD_W] = mem[(base + k*DIM + j) & 255];
        return p;
    endfunction

    function automatic bit exp_reject(input int base, input int num);
        return (num == 0) || (base + num * DIM > 256);
    endfunction

    task automatic wait_done(input int pct, output int n);
        n = 0;
        while (!done && n < LIMIT) begin
            pt_ready = ($urandom_range(0, 99) < pct);
            tick();
            n++;
        end
        pt_ready = 1'b0;
        chk("request_completes", n < LIMIT, 1'b1);
        tick();
        tick();
    endtask

    task automatic run_req(input int base, input int num, input int pct, output int n);
        mon_clear();
        base_addr = ADDR_W'(base);
        num_pts   = CNT_W'(num);
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done(pct, n);
    endtask

    task automatic check_req(input int base, input int num, input bit exp_err, input int n);
        int exp_pts;
        int bad;
        exp_pts = exp_err ? 0 : num;
        chk("done_pulses", done_cnt, 1);
        chk("err_pulses", err_cnt, exp_err);
        if (exp_err) chk("reject_latency", n, 0);
        chk("read_count", rd_q.size(), exp_pts * DIM);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] != ADDR_W'(base + i)) bad++;
        chk("read_addrs_bad", bad, 0);
        chk("point_count", hs_data.size(), exp_pts);
        bad = 0;
        foreach (hs_data[i]) if (hs_data[i] !== exp_pt(base, i) || hs_idx[i] != CNT_W'(i)) bad++;
        chk("points_bad", bad, 0);
    endtask

    typedef struct {
        int            base;
        int            num;
        bit            exp_err;
        int            exp_reads;
        logic [PW-1:0] exp_pt0;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, lat, base, num;
        logic [PW-1:0] p345;

        for (int i = 0; i < 256; i++) mem[i] = (i < 16) ? COORD_W'(i + 3) : $urandom;
        p345 = {32'd5, 32'd4, 32'd3};

        tbl[0] = '{0,   2,   1'b0, 6,   p345};
        tbl[1] = '{0,   0,   1'b1, 0,   '0};
        tbl[2] = '{4,   1,   1'b0, 3,   {32'd9, 32'd8, 32'd7}};
        tbl[3] = '{254, 1,   1'b1, 0,   '0};
        tbl[4] = '{253, 1,   1'b0, 3,   exp_pt(253, 0)};
        tbl[5] = '{85,  57,  1'b0, 171, exp_pt(85, 0)};
        tbl[6] = '{85,  58,  1'b1, 0,   '0};
        tbl[7] = '{0,   255, 1'b1, 0,   '0};
        tbl[8] = '{200, 100, 1'b1, 0,   '0};

        rst = 1'b1; abort = 1'b0; start = 1'b0; pt_ready = 1'b0;
        base_addr = '0; num_pts = '0;
        mon_clear();
        tick(); tick(); tick();
        chk("reset_outputs", {busy, done, err, mem_rd_en, mem_addr, pt_valid, pt_index, pt_data}, '0);
        rst = 1'b0;
        tick();

        // Table of requests, consumer always ready.
        for (int i = 0; i < 9; i++) begin
            run_req(tbl[i].base, tbl[i].num, 100, n);
            chk("tbl_err", err_cnt, tbl[i].exp_err);
            chk("tbl_reads", rd_q.size(), tbl[i].exp_reads);
            chk("tbl_pt0", (hs_data.size() > 0) ? hs_data[0] : '0, tbl[i].exp_pt0);
            check_req(tbl[i].base, tbl[i].num, tbl[i].exp_err, n);
        end

        // Latency and backpressure: hold pt_ready low for 10 EMIT cycles.
        mon_clear();
        base_addr = 8'd0; num_pts = 8'd2; start = 1'b1; pt_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("first_read", {busy, mem_rd_en, mem_addr}, {1'b1, 1'b1, 8'd0});
        lat = 1;
        while (!pt_valid && lat < 50) begin tick(); lat++; end
        chk("first_valid_latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            chk("backpressure_hold", {pt_valid, mem_rd_en, pt_index, pt_data}, {1'b1, 1'b0, 8'd0, p345});
            tick();
        end
        pt_ready = 1'b1;
        tick();
        chk("after_handshake", {pt_valid, mem_rd_en, mem_addr, pt_index}, {1'b0, 1'b1, 8'd3, 8'd1});
        wait_done(100, n);
        check_req(0, 2, 1'b0, n);

        // Reset while a point is pending.
        mon_clear();
        base_addr = 8'd0; num_pts = 8'd2; start = 1'b1; pt_ready = 1'b0;
        tick();
        start = 1'b0;
        lat = 0;
        while (!pt_valid && lat < 50) begin tick(); lat++; end
        rst = 1'b1;
        tick();
        chk("reset_mid_emit", {busy, done, err, mem_rd_en, pt_valid, pt_index, pt_data}, '0);
        rst = 1'b0;
        tick(); tick();
        chk("reset_no_done", done_cnt, 0);
        run_req(0, 1, 100, n);
        check_req(0, 1, 1'b0, n);

        // start held high while busy is ignored.
        mon_clear();
        base_addr = 8'd0; num_pts = 8'd2; start = 1'b1;
        tick();
        base_addr = 8'd4; num_pts = 8'd1;
        n = 0;
        while (!done && n < LIMIT) begin pt_ready = 1'b1; tick(); n++; end
        start = 1'b0;
        pt_ready = 1'b0;
        tick(); tick(); tick();
        check_req(0, 2, 1'b0, 1);

`ifdef PFC_ABORT_EN
        // Abort during the fetch of point 1.
        mon_clear();
        base_addr = 8'd0; num_pts = 8'd2; start = 1'b1; pt_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(mem_rd_en && pt_index == 8'd1) && n < 50) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_response", {done, err, pt_valid, mem_rd_en, busy}, 5'b11000);
        tick();
        chk("abort_pulse_end", {done, err, busy}, 3'b000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_idle", {done, err, busy}, 3'b000);
        pt_ready = 1'b0;
        tick();
`endif

        // Random requests with random consumer stalls.
        for (int r = 0; r < 40; r++) begin
            base = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) num = (256 - base) / DIM + $urandom_range(0, 1);
            else if ($urandom_range(0, 5) == 0) num = 0;
            else num = $urandom_range(1, 30);
            run_req(base, num, 70, n);
            check_req(base, num, exp_reject(base, num), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
